exc_code_encoder: RTL

- Producer side of the exception-code interface consumed by the clock/mode controller.
- Converts CPU-side event pulses into a 4-bit exception code: illegal instruction, memory fault, ecall, UART load done and resume.
- Holds each code stable until the controller's mode output confirms the transition; then releases to 0.
- Queues events that arrive while a code is in flight. Sits between the CPU core/decoder and the mode controller.

---
 rtl/exc_code_encoder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/exc_code_encoder.sv
// Exception-code producer: turns CPU event pulses into held 4-bit codes for the mode controller.
// Optional build macro EXC_STATS_EN adds exc_cnt_o, a saturating count of acknowledged codes.
module exc_code_encoder #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] ECALL_EXIT  = 32'd10,
  parameter logic [31:0] ECALL_UART  = 32'd50
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        illegal_instr_i,
  input  logic        mem_fault_i,
  input  logic        ecall_i,
  input  logic [31:0] ecall_num_i,
  input  logic        uart_done_i,
  input  logic        resume_i,
  input  logic [3:0]  mode_i,
  output logic [3:0]  exc_code_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        timeout_o
`ifdef EXC_STATS_EN
  ,
  output logic [15:0] exc_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0] MODE_ERROR = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [3:0]    code_r, tgt_r;
  logic [TW-1:0] timer_r;

  logic          ev_valid_s, ev_fault_s;
  logic [7:0]    ev_entry_s;
  logic          pop_s, full_s, push_s, drop_s;
  logic [7:0]    head_s;
  logic          ack_s, timeout_set_s;
  logic [3:0]    exc_code_nxt_s;
  logic          busy_nxt_s;

  logic [3:0]    exc_code_r;
  logic          busy_r, overflow_r, timeout_r;

  // Priority event decode; an unmapped ecall number does not mask lower events
  always_comb begin
    ev_valid_s = 1'b1;
    ev_fault_s = 1'b0;
    ev_entry_s = 8'h00;
    if (mem_fault_i || illegal_instr_i) begin
      ev_fault_s = 1'b1;
      ev_entry_s = {4'd2, 4'd2};
    end else if (ecall_i && (ecall_num_i == ECALL_EXIT)) begin
      ev_entry_s = {4'd4, 4'd4};
    end else if (ecall_i && (ecall_num_i == ECALL_UART)) begin
      ev_entry_s = {4'd5, 4'd6};
    end else if (uart_done_i) begin
      ev_entry_s = {4'd6, 4'd5};
    end else if (resume_i) begin
      ev_entry_s = {4'd1, 4'd5};
    end else begin
      ev_valid_s = 1'b0;
    end
  end

  assign head_s = mem_r[rd_ptr_r];
  assign pop_s  = (state_r == ST_IDLE) && (count_r != {CW{1'b0}});
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign full_s = (count_r == CNT_FULL) && !pop_s;
  assign push_s = ev_valid_s && !ev_fault_s && !full_s;
  assign drop_s = ev_valid_s && !ev_fault_s && full_s;

  // Occupancy after this edge; a fault leaves exactly itself queued
  always_comb begin
    count_nxt_s = count_r;
    if (ev_valid_s && ev_fault_s) begin
      count_nxt_s = CNT_ONE;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // FIFO storage, pointers and sticky overflow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if ((ev_valid_s && ev_fault_s) || push_s) begin
        mem_r[wr_ptr_r] <= ev_entry_s;
      end
      if (ev_valid_s && ev_fault_s) begin
        rd_ptr_r <= wr_ptr_r;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: acknowledge beats error-mode abandon, which beats timeout
  always_comb begin
    state_nxt_s   = state_r;
    ack_s         = 1'b0;
    timeout_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_nxt_s = ST_DRIVE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_DRIVE: begin
        if (mode_i == tgt_r) begin
          ack_s       = 1'b1;
          state_nxt_s = ST_RELEASE;
        end else if ((mode_i == MODE_ERROR) && (code_r != 4'd2)) begin
          state_nxt_s = ST_RELEASE;
        end else if (timer_r == TMR_LAST) begin
          timeout_set_s = 1'b1;
          state_nxt_s   = ST_RELEASE;
        end else begin
          state_nxt_s = ST_DRIVE;
        end
      end
      ST_RELEASE: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode, computed one cycle ahead so the outputs come straight from flops
  always_comb begin
    exc_code_nxt_s = 4'd0;
    if (state_nxt_s == ST_DRIVE) begin
      if (pop_s) exc_code_nxt_s = head_s[7:4];
      else       exc_code_nxt_s = code_r;
    end else begin
      exc_code_nxt_s = 4'd0;
    end
    busy_nxt_s = (state_nxt_s != ST_IDLE) || (count_nxt_s != {CW{1'b0}});
  end

  // In-flight code, hold timer and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      code_r     <= 4'd0;
      tgt_r      <= 4'd0;
      timer_r    <= {TW{1'b0}};
      exc_code_r <= 4'd0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      if (pop_s) begin
        code_r <= head_s[7:4];
        tgt_r  <= head_s[3:0];
      end
      if ((state_r == ST_DRIVE) && (state_nxt_s == ST_DRIVE)) timer_r <= timer_r + TW'(1);
      else                                                     timer_r <= {TW{1'b0}};
      exc_code_r <= exc_code_nxt_s;
      busy_r     <= busy_nxt_s;
      if (timeout_set_s) timeout_r <= 1'b1;
    end
  end

`ifdef EXC_STATS_EN
  logic [15:0] exc_cnt_r;

  // Saturating count of acknowledged codes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exc_cnt_r <= 16'h0000;
    end else if (ack_s && (exc_cnt_r != 16'hFFFF)) begin
      exc_cnt_r <= exc_cnt_r + 16'h0001;
    end
  end

  assign exc_cnt_o = exc_cnt_r;
`endif

  assign exc_code_o = exc_code_r;
  assign busy_o     = busy_r;
  assign overflow_o = overflow_r;
  assign timeout_o  = timeout_r;

endmodule
